uart_io_ctrl: RTL and testbench
===============================

Name: uart_io_ctrl

Overview:
- Owns the UART byte streams for the core and sequences them.
- Buffers received bytes in an RX ring FIFO and serves IN-instruction requests from it.
- Queues OUT-instruction bytes in a TX ring FIFO and drives the uart_tx start/busy handshake to drain it.
- Sends the one-time 0xAA loader sync byte in LOAD mode.
- Sits between the execute stage (request/ack, stall) and the uart_rx/uart_tx byte engines.

Parameters:
- DEPTH_LOG2, 4, log2 of each FIFO depth (RX and TX are both 2**DEPTH_LOG2 entries).
- SYNC_BYTE, 8'hAA, byte transmitted once in LOAD mode.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- mode  in  3  0 = idle, 1 = LOAD, 2 = EXEC, other values treated as idle
- rx_data  in  8  byte from uart_rx
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_busy  in  1  uart_tx busy
- tx_start  out  1  one-cycle start pulse to uart_tx
- tx_data  out  8  byte to uart_tx, held stable while tx_busy
- in_req  in  1  IN instruction requests a byte (level)
- in_ack  out  1  one-cycle, in_data valid
- in_data  out  32  {24'b0, byte}
- out_req  in  1  OUT instruction requests a push (level)
- out_byte  in  8  byte to push
- out_ack  out  1  one-cycle, byte accepted
- busy  out  1  stall to pipeline
- sync_sent  out  1  sticky, SYNC_BYTE transmission completed
- rx_overflow  out  1  sticky, an RX byte was dropped
- rx_count  out  DEPTH_LOG2+1  RX FIFO occupancy
- tx_count  out  DEPTH_LOG2+1  TX FIFO occupancy

Behaviour:
- Reset values: all outputs 0; FIFO pointers and counts 0; TX FSM in T_IDLE. Reset mid-transfer abandons any byte in flight and empties both FIFOs.
- RX FIFO push:
  - Push when rx_valid && mode==2.
  - When full (rx_count==2**DEPTH_LOG2), the byte is dropped and rx_overflow is set (it clears only on rst).
  - rx_valid in any other mode is ignored.
- IN handshake:
  - Accept when in_req && !in_ack && rx_count!=0.
  - On accept: pop the head and register in_data={24'b0,head}. in_ack=1 in the next cycle only.
  - in_data holds until the next ack.
  - in_req is ignored during the in_ack cycle, so one request yields one byte.
- Simultaneous RX push and IN pop in one cycle: both happen and rx_count is unchanged. Pushing into a full FIFO while popping in the same cycle is accepted (not an overflow).
- OUT handshake:
  - Accept when out_req && !out_ack && tx_count!=2**DEPTH_LOG2.
  - On accept: push out_byte and set out_ack=1 in the next cycle.
  - When the FIFO is full, stall until the TX FSM pops an entry.
- busy = (in_req && !in_ack) || (out_req && !out_ack). Combinational.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Counts are DEPTH_LOG2+1 bits, so full and empty are unambiguous.
- TX FSM states: T_IDLE, T_START, T_HOLD, T_WAIT.
  - T_IDLE, sync path: if mode==1 && !sync_sent, load tx_data=SYNC_BYTE, mark the byte as sync, go to T_START.
  - T_IDLE, data path: else if mode!=1 && tx_count!=0 && !tx_busy, pop the head into tx_data (pop in this cycle) and go to T_START.
  - T_START: tx_start=1 for exactly one cycle, then go to T_HOLD.
  - T_HOLD: one cycle for uart_tx to raise busy, then go to T_WAIT.
  - T_WAIT: when !tx_busy, go to T_IDLE. If the byte was sync, set sync_sent at this transition.
- In LOAD mode FIFO draining is paused; the sync byte has priority. Bytes remain queued until mode leaves 1.
- A push and a TX pop in the same cycle are both performed.
- Minimum spacing between tx_start pulses: 3 cycles plus the uart_tx busy time.

Test Plan:
- Reset, then mode=1 and hold; uart_tx model busy for 20 cycles → exactly one tx_start with tx_data=8'hAA; sync_sent=1 after busy falls; no second start over the next 100 cycles.
- mode=2, inject rx bytes 0x41,0x42,0x43 → rx_count=3. Then in_req high for three requests → in_ack pulses with in_data=0x41, 0x42, 0x43 in order; rx_count=0.
- mode=2, in_req high with the FIFO empty → busy=1 for 10 cycles; rx_valid with 0x5A → in_ack one cycle later than the push is visible, in_data=0x0000005A, busy drops.
- Inject 17 rx bytes with DEPTH_LOG2=4 and no pops → rx_count=16, rx_overflow=1; the 17th byte is never returned. Same-cycle push and pop at full → count stays 16 and rx_overflow is not set by it.
- mode=2, issue 17 OUT requests 0x00..0x10 with uart_tx busy for 30 cycles per byte → 17th out_ack is delayed until the first pop; bytes leave in order 0x00..0x10; tx_count returns to 0.
- Assert rst during T_WAIT with tx_count=5 → next cycle tx_start=0, both counts 0, sync_sent=0, all acks 0.

Source files
------------

// File: rtl/uart_io_ctrl.sv
// rtl/uart_io_ctrl.sv - UART byte-stream sequencer with RX/TX ring FIFOs and loader sync
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   mode[2:0]             0 idle, 1 LOAD, 2 EXEC, others idle
//   rx_data, rx_valid     byte strobe from uart_rx
//   tx_busy               busy from uart_tx
//   tx_start, tx_data     start pulse and held byte to uart_tx
//   in_req/in_ack/in_data IN instruction handshake, in_data = {24'b0, byte}
//   out_req/out_byte/out_ack  OUT instruction handshake
//   busy                  pipeline stall (combinational)
//   sync_sent             sticky, sync byte fully transmitted
//   rx_overflow           sticky, an RX byte was dropped
//   rx_count, tx_count    FIFO occupancies
module uart_io_ctrl #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hAA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            mode,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  in_req,
  output logic                  in_ack,
  output logic [31:0]           in_data,
  input  logic                  out_req,
  input  logic [7:0]            out_byte,
  output logic                  out_ack,
  output logic                  busy,
  output logic                  sync_sent,
  output logic                  rx_overflow,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic [DEPTH_LOG2:0]   tx_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {T_IDLE, T_START, T_HOLD, T_WAIT} tx_state_t;

  logic [7:0]            rx_mem [DEPTH];
  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wptr, rx_rptr, tx_wptr, tx_rptr;

  logic      rx_push_req, rx_push, in_accept, out_accept, tx_pop;
  logic      load_sync, set_sync, is_sync;
  tx_state_t state, state_n;

  assign rx_push_req = rx_valid && (mode == 3'd2);
  assign in_accept   = in_req && !in_ack && (rx_count != '0);
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign rx_push     = rx_push_req && ((rx_count != FULL) || in_accept);
  assign out_accept  = out_req && !out_ack && (tx_count != FULL);
  assign busy        = (in_req && !in_ack) || (out_req && !out_ack);

  // Storage arrays carry no reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
    if (out_accept) tx_mem[tx_wptr] <= out_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr     <= '0;
      rx_rptr     <= '0;
      rx_count    <= '0;
      rx_overflow <= 1'b0;
      in_ack      <= 1'b0;
      in_data     <= '0;
    end else begin
      in_ack <= in_accept;
      if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
      if (in_accept) begin
        rx_rptr <= rx_rptr + PTR_ONE;
        in_data <= {24'b0, rx_mem[rx_rptr]};
      end
      if (rx_push_req && !rx_push) rx_overflow <= 1'b1;
      case ({rx_push, in_accept})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
      out_ack  <= 1'b0;
    end else begin
      out_ack <= out_accept;
      if (out_accept) tx_wptr <= tx_wptr + PTR_ONE;
      if (tx_pop) tx_rptr <= tx_rptr + PTR_ONE;
      case ({out_accept, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // The sync byte wins in LOAD mode; queued data waits until mode leaves LOAD.
  always_comb begin
    state_n   = state;
    tx_pop    = 1'b0;
    load_sync = 1'b0;
    set_sync  = 1'b0;
    case (state)
      T_IDLE: begin
        if (mode == 3'd1 && !sync_sent) begin
          load_sync = 1'b1;
          state_n   = T_START;
        end else if (mode != 3'd1 && tx_count != '0 && !tx_busy) begin
          tx_pop  = 1'b1;
          state_n = T_START;
        end
      end
      T_START: state_n = T_HOLD;
      // Gives uart_tx one cycle to raise busy before we look at it.
      T_HOLD:  state_n = T_WAIT;
      T_WAIT: begin
        if (!tx_busy) begin
          state_n  = T_IDLE;
          set_sync = is_sync;
        end
      end
      default: state_n = T_IDLE;
    endcase
  end

  assign tx_start = (state == T_START);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= T_IDLE;
      tx_data   <= '0;
      is_sync   <= 1'b0;
      sync_sent <= 1'b0;
    end else begin
      state <= state_n;
      if (load_sync) begin
        tx_data <= SYNC_BYTE;
        is_sync <= 1'b1;
      end else if (tx_pop) begin
        tx_data <= tx_mem[tx_rptr];
        is_sync <= 1'b0;
      end
      if (set_sync) sync_sent <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// tb/tb_uart_io_ctrl.sv - self-checking bench for uart_io_ctrl with queue reference model
module tb_uart_io_ctrl;

  logic        clk, rst;
  logic [2:0]  mode;
  logic [7:0]  rx_data;
  logic        rx_valid, tx_busy, tx_start;
  logic [7:0]  tx_data;
  logic        in_req, in_ack;
  logic [31:0] in_data;
  logic        out_req;
  logic [7:0]  out_byte;
  logic        out_ack, busy, sync_sent, rx_overflow;
  logic [4:0]  rx_count, tx_count;

  uart_io_ctrl #(.DEPTH_LOG2(4), .SYNC_BYTE(8'hAA)) dut (
    .clk(clk), .rst(rst), .mode(mode), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
    .out_req(out_req), .out_byte(out_byte), .out_ack(out_ack),
    .busy(busy), .sync_sent(sync_sent), .rx_overflow(rx_overflow),
    .rx_count(rx_count), .tx_count(tx_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as plain queues.
  logic [7:0] rx_q [$];
  logic [7:0] tx_exp [$];
  logic [7:0] tx_obs [$];
  int         start_cnt = 0;
  int         busy_len = 20;
  bit         rand_busy = 0;
  bit         hold_busy = 0;
  int         busy_cnt = 0;
  logic [7:0] cur_byte = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  // uart_tx behaviour: busy starts right after the start pulse and lasts N cycles.
  initial begin
    tx_busy = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else if (tx_start) begin
        cur_byte = tx_data;
        tx_obs.push_back(tx_data);
        start_cnt++;
        busy_cnt = rand_busy ? $urandom_range(1, 8) : busy_len;
      end else if (busy_cnt > 0) begin
        chk("tx_data_hold", tx_data, cur_byte);
        busy_cnt--;
      end
      tx_busy = hold_busy || (busy_cnt != 0);
    end
  end

  // IN results are checked against the model queue as they appear.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && in_ack) begin
        if (rx_q.size() == 0) chk("in_extra", 1, 0);
        else chk("in_data", in_data, {24'b0, rx_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    rst = 1; mode = 0; rx_valid = 0; rx_data = 0; in_req = 0; out_req = 0;
    out_byte = 0; hold_busy = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    rx_q.delete(); tx_exp.delete(); tx_obs.delete(); start_cnt = 0;
  endtask

  task automatic rx_push(input logic [7:0] b, input bit keep);
    rx_valid = 1; rx_data = b;
    if (keep) rx_q.push_back(b);
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic do_in();
    int n = 0;
    in_req = 1;
    do begin @(negedge clk); n++; end while (!in_ack && n < 500);
    in_req = 0;
    if (n >= 500) chk("in_timeout", 0, 1);
  endtask

  task automatic do_out(input logic [7:0] b);
    int n = 0;
    out_req = 1; out_byte = b;
    do begin @(negedge clk); n++; end while (!out_ack && n < 500);
    out_req = 0;
    tx_exp.push_back(b);
    if (n >= 500) chk("out_timeout", 0, 1);
  endtask

  task automatic wait_tx_drain();
    int n = 0;
    while ((tx_count != 0 || tx_busy || tx_obs.size() < tx_exp.size()) && n < 2000) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
    if (n >= 2000) chk("drain_timeout", 0, 1);
  endtask

  task automatic cmp_tx();
    chk("tx_obs_size", tx_obs.size(), tx_exp.size());
    for (int i = 0; i < tx_exp.size() && i < tx_obs.size(); i++)
      chk("tx_order", tx_obs[i], tx_exp[i]);
  endtask

  initial begin
    logic [7:0] b;
    int n;
    @(negedge clk);
    do_reset();

    // reset state
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_in_ack", in_ack, 0);
    chk("rst_in_data", in_data, 0);
    chk("rst_out_ack", out_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sync_sent", sync_sent, 0);
    chk("rst_overflow", rx_overflow, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_tx_count", tx_count, 0);

    // LOAD mode: one sync byte only
    busy_len = 20;
    mode = 1;
    n = 0;
    while (start_cnt == 0 && n < 50) begin @(negedge clk); n++; end
    chk("sync_start_seen", start_cnt, 1);
    chk("sync_byte", tx_data, 8'hAA);
    repeat (5) @(negedge clk);
    chk("sync_sent_during_busy", sync_sent, 0);
    repeat (25) @(negedge clk);
    chk("sync_sent_after", sync_sent, 1);
    repeat (100) @(negedge clk);
    chk("sync_once", start_cnt, 1);

    // reset in the middle of a transmission with 5 bytes queued
    mode = 2; busy_len = 50;
    rx_push(8'h77, 1);
    for (int i = 0; i < 6; i++) do_out(8'(i + 8'h30));
    chk("pre_rst_tx_count", tx_count, 5);
    chk("pre_rst_rx_count", rx_count, 1);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrst_tx_start", tx_start, 0);
    chk("midrst_tx_count", tx_count, 0);
    chk("midrst_rx_count", rx_count, 0);
    chk("midrst_sync_sent", sync_sent, 0);
    chk("midrst_in_ack", in_ack, 0);
    chk("midrst_out_ack", out_ack, 0);
    do_reset();
    repeat (3) @(negedge clk);
    chk("postrst_no_start", start_cnt, 0);

    // EXEC: three bytes in, three IN requests
    mode = 2;
    rx_push(8'h41, 1); rx_push(8'h42, 1); rx_push(8'h43, 1);
    chk("rx_count_3", rx_count, 3);
    for (int i = 0; i < 3; i++) do_in();
    @(negedge clk);
    chk("rx_count_0", rx_count, 0);

    // IN on empty FIFO stalls until a byte arrives
    in_req = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_busy", busy, 1);
      chk("stall_no_ack", in_ack, 0);
    end
    rx_push(8'h5A, 1);
    chk("late_count", rx_count, 1);
    chk("late_ack_not_yet", in_ack, 0);
    @(negedge clk);
    chk("late_ack", in_ack, 1);
    chk("late_data", in_data, 32'h0000005A);
    chk("late_busy_drop", busy, 0);
    in_req = 0;
    @(negedge clk);

    // RX full: simultaneous push/pop, then a dropped byte
    do_reset();
    mode = 2;
    for (int i = 0; i < 16; i++) rx_push(8'($urandom), 1);
    chk("rx_full_count", rx_count, 16);
    chk("rx_full_no_ovf", rx_overflow, 0);
    in_req = 1; rx_valid = 1; rx_data = 8'($urandom); rx_q.push_back(rx_data);
    @(negedge clk);
    in_req = 0; rx_valid = 0;
    chk("pushpop_ack", in_ack, 1);
    chk("pushpop_count", rx_count, 16);
    chk("pushpop_no_ovf", rx_overflow, 0);
    @(negedge clk);
    rx_push(8'hEE, 0);
    chk("drop_count", rx_count, 16);
    chk("drop_ovf", rx_overflow, 1);
    for (int i = 0; i < 16; i++) do_in();
    @(negedge clk);
    chk("drained_rx", rx_count, 0);
    chk("ovf_sticky", rx_overflow, 1);
    chk("model_rx_empty", rx_q.size(), 0);

    // TX full: 17 OUT requests, 17th waits for the first pop
    do_reset();
    mode = 2; busy_len = 30;
    hold_busy = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) do_out(8'(i));
    chk("tx_full_count", tx_count, 16);
    out_req = 1; out_byte = 8'h10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("tx_full_no_ack", out_ack, 0);
      chk("tx_full_busy", busy, 1);
    end
    hold_busy = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_ack && n < 100);
    out_req = 0;
    tx_exp.push_back(8'h10);
    chk("tx_17th_ack", out_ack, 1);
    wait_tx_drain();
    chk("tx_count_0", tx_count, 0);
    cmp_tx();

    // randomized mixed traffic
    do_reset();
    mode = 2; rand_busy = 1;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          int w = 0;
          while (rx_q.size() >= 16 && w < 500) begin @(negedge clk); w++; end
          rx_push(8'($urandom), 1);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          do_in();
          repeat ($urandom_range(0, 4)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          do_out(8'($urandom));
          repeat ($urandom_range(0, 5)) @(negedge clk);
        end
      end
    join
    wait_tx_drain();
    cmp_tx();
    chk("rand_rx_count", rx_count, 0);
    chk("rand_no_ovf", rx_overflow, 0);
    chk("rand_model_empty", rx_q.size(), 0);
    chk("rand_no_sync", sync_sent, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
